// File: rtl/ps2_kbd_buf_if.sv
// Keyboard-buffer bus: scanner inputs, CPU pop/clear controls and FIFO status.
interface ps2_kbd_buf_if #(
    parameter int PTR_W = 3
);
    logic [7:0]     ps2_byte;
    logic           ps2_intp;
    logic           caps_flg;
    logic           rd_en;
    logic           ovf_clr;
    logic [7:0]     dout;
    logic           empty;
    logic           full;
    logic [PTR_W:0] count;
    logic           ovf;
    logic           irq;

    modport master (
        output ps2_byte, ps2_intp, caps_flg, rd_en, ovf_clr,
        input  dout, empty, full, count, ovf, irq
    );

    modport slave (
        input  ps2_byte, ps2_intp, caps_flg, rd_en, ovf_clr,
        output dout, empty, full, count, ovf, irq
    );
endinterface

// File: rtl/ps2_kbd_buf.sv
// PS/2 set-2 make code to ASCII translator feeding a first-word-fall-through FIFO.
module ps2_kbd_buf #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    ps2_kbd_buf_if.slave      bus
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Returns 1 with the ASCII char when the code is mapped; caps only affects letters.
    function automatic logic xlate(input logic [7:0] code, input logic caps,
                                   output logic [7:0] ch);
        logic       hit;
        logic       letter;
        logic [7:0] c;
        hit    = 1'b1;
        letter = 1'b1;
        c      = 8'h00;
        case (code)
            8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;
            8'h23: c = 8'h64;  8'h24: c = 8'h65;  8'h2B: c = 8'h66;
            8'h34: c = 8'h67;  8'h33: c = 8'h68;  8'h43: c = 8'h69;
            8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
            8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;
            8'h4D: c = 8'h70;  8'h15: c = 8'h71;  8'h2D: c = 8'h72;
            8'h1B: c = 8'h73;  8'h2C: c = 8'h74;  8'h3C: c = 8'h75;
            8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
            8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45: c = 8'h30;  8'h16: c = 8'h31;  8'h1E: c = 8'h32;
                    8'h26: c = 8'h33;  8'h25: c = 8'h34;  8'h2E: c = 8'h35;
                    8'h36: c = 8'h36;  8'h3D: c = 8'h37;  8'h3E: c = 8'h38;
                    8'h46: c = 8'h39;
                    8'h29: c = 8'h20;  8'h5A: c = 8'h0D;
                    8'h66: c = 8'h08;  8'h76: c = 8'h1B;
                    default: hit = 1'b0;
                endcase
            end
        endcase
        ch = (letter && caps) ? (c - 8'h20) : c;
        return hit;
    endfunction

    logic             s1_vld;
    logic [7:0]       s1_chr;
    logic             map_hit;
    logic [7:0]       map_chr;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             ovf_q;

    logic             is_empty;
    logic             is_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    always_comb begin
        map_chr = 8'h00;
        map_hit = xlate(bus.ps2_byte, bus.caps_flg, map_chr);
    end

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);
    assign pop      = bus.rd_en && !is_empty;
    // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
    assign push_ok  = s1_vld && (!is_full || pop);
    assign drop     = s1_vld && is_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_chr <= 8'h00;
        end else begin
            s1_vld <= bus.ps2_intp && map_hit;
            if (bus.ps2_intp && map_hit)
                s1_chr <= map_chr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // Storage carries no reset; dout is gated by empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= s1_chr;
    end

    assign bus.dout  = is_empty ? 8'h00 : mem[rd_ptr];
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.count = cnt;
    assign bus.ovf   = ovf_q;
    assign bus.irq   = !is_empty;
endmodule

// File: tb/tb_ps2_kbd_buf.sv
// Directed plus randomized checks of ps2_kbd_buf against a queue-based reference model.
module tb_ps2_kbd_buf;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_kbd_buf_if #(.PTR_W(PTR_W)) bus ();
    ps2_kbd_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
    logic [7:0] ctl_codes [4]  = '{8'h29, 8'h5A, 8'h66, 8'h76};
    logic [7:0] ctl_chars [4]  = '{8'h20, 8'h0D, 8'h08, 8'h1B};

    // Reference state: characters held, translation waiting one cycle, overflow flag.
    logic [7:0] q [$];
    bit         pend_v;
    logic [7:0] pend_c;
    bit         m_ovf;

    function automatic bit xlate(input logic [7:0] code, input bit caps, output logic [7:0] ch);
        ch = 8'h00;
        for (int i = 0; i < 26; i++)
            if (code == let_codes[i]) begin
                ch = caps ? 8'(8'h41 + i) : 8'(8'h61 + i);
                return 1'b1;
            end
        for (int i = 0; i < 10; i++)
            if (code == dig_codes[i]) begin
                ch = 8'(8'h30 + i);
                return 1'b1;
            end
        for (int i = 0; i < 4; i++)
            if (code == ctl_codes[i]) begin
                ch = ctl_chars[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("count", 32'(bus.count), q.size());
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("full",  32'(bus.full),  32'(q.size() == DEPTH));
        chk("irq",   32'(bus.irq),   32'(q.size() != 0));
        chk("ovf",   32'(bus.ovf),   32'(m_ovf));
        chk("dout",  32'(bus.dout),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    endtask

    task automatic cyc(input bit intp, input logic [7:0] b, input bit caps,
                       input bit rd, input bit clr, input bit r);
        bit         popd;
        bit         dropped;
        bit         hit;
        logic [7:0] ch;
        bus.ps2_intp = intp;
        bus.ps2_byte = b;
        bus.caps_flg = caps;
        bus.rd_en    = rd;
        bus.ovf_clr  = clr;
        rst          = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            pend_v = 0;
            m_ovf  = 0;
        end else begin
            popd    = rd && (q.size() > 0);
            dropped = pend_v && (q.size() == DEPTH) && !popd;
            if (popd)
                void'(q.pop_front());
            if (pend_v && !dropped)
                q.push_back(pend_c);
            if (dropped)
                m_ovf = 1;
            else if (clr)
                m_ovf = 0;
            hit    = xlate(b, caps, ch);
            pend_v = intp && hit;
            if (pend_v)
                pend_c = ch;
        end
        #1;
        chk_model();
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic pop1();
        cyc(0, 8'h00, 0, 1, 0, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         k;
        bus.ps2_intp = 0;
        bus.ps2_byte = 8'h00;
        bus.caps_flg = 0;
        bus.rd_en    = 0;
        bus.ovf_clr  = 0;
        pend_v = 0;
        pend_c = 8'h00;
        m_ovf  = 0;

        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(1, 8'h1C, 0, 1, 0, 1);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_dout",  32'(bus.dout),  32'h00);
        idle();
        chk("rst_ignores_intp", 32'(bus.count), 32'd0);

        // Single 'a', two-cycle latency, then pop to empty
        cyc(1, 8'h1C, 0, 0, 0, 0);
        chk("lat_n1_empty", 32'(bus.empty), 32'd1);
        idle();
        chk("a_dout", 32'(bus.dout), 32'h61);
        chk("a_count", 32'(bus.count), 32'd1);
        chk("a_irq", 32'(bus.irq), 32'd1);
        pop1();
        chk("a_popped_empty", 32'(bus.empty), 32'd1);
        chk("a_popped_dout", 32'(bus.dout), 32'h00);
        pop1();
        chk("pop_on_empty", 32'(bus.count), 32'd0);

        // CapsLock: uppercase letter, digit unaffected
        cyc(1, 8'h1A, 1, 0, 0, 0);
        cyc(1, 8'h45, 1, 0, 0, 0);
        idle();
        chk("caps_Z", 32'(bus.dout), 32'h5A);
        pop1();
        chk("caps_0", 32'(bus.dout), 32'h30);
        pop1();

        // Unmapped codes push nothing
        cyc(1, 8'h58, 0, 0, 0, 0);
        cyc(1, 8'hE0, 1, 0, 0, 0);
        idle();
        idle();
        chk("unmapped_count", 32'(bus.count), 32'd0);
        chk("unmapped_ovf", 32'(bus.ovf), 32'd0);

        // Nine letters with no reads: overflow on the ninth
        for (int i = 0; i < 9; i++)
            cyc(1, let_codes[i], 0, 0, 0, 0);
        idle();
        idle();
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_order", 32'(bus.dout), 32'(8'h61 + i));
            pop1();
        end
        cyc(0, 8'h00, 0, 0, 1, 0);
        chk("ovf_clr", 32'(bus.ovf), 32'd0);

        // Full FIFO, push coincides with pop: accepted, no overflow
        for (int i = 0; i < 8; i++)
            cyc(1, let_codes[i], 0, 0, 0, 0);
        idle();
        cyc(1, 8'h1A, 0, 0, 0, 0);
        pop1();
        chk("pp_count", 32'(bus.count), 32'd8);
        chk("pp_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 7; i++)
            pop1();
        chk("pp_last_z", 32'(bus.dout), 32'h7A);
        pop1();

        // Drop coincident with ovf_clr: set wins
        for (int i = 0; i < 9; i++)
            cyc(1, let_codes[i], 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1, 0);
        chk("set_wins", 32'(bus.ovf), 32'd1);

        // Reset one cycle after a key: translation in flight is lost
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(1, 8'h1C, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 1);
        idle();
        idle();
        chk("flight_count", 32'(bus.count), 32'd0);
        chk("flight_empty", 32'(bus.empty), 32'd1);

        for (int n = 0; n < 800; n++) begin
            k = $urandom_range(0, 40);
            if (k < 26)      b = let_codes[k];
            else if (k < 36) b = dig_codes[k-26];
            else if (k < 40) b = ctl_codes[k-36];
            else             b = 8'($urandom_range(0, 255));
            cyc(($urandom_range(0, 1) == 1), b, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
